// File: rtl/dlx_data_mem_responder_if.sv
// rtl/dlx_data_mem_responder_if.sv - data-memory request/response bundle between pipeline and responder
interface dlx_data_mem_responder_if #(
  parameter int WBUF_DEPTH = 4
);
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic [31:0]      mem_addr;
  logic             mem_en;
  logic [31:0]      memdata_out;
  logic [31:0]      memdata_in;
  logic [CNT_W-1:0] wbuf_count;
  logic             wbuf_full;
  logic             store_drop;
  logic             overflow;

  modport master (
    output mem_addr, mem_en, memdata_out,
    input  memdata_in, wbuf_count, wbuf_full, store_drop, overflow
  );

  modport slave (
    input  mem_addr, mem_en, memdata_out,
    output memdata_in, wbuf_count, wbuf_full, store_drop, overflow
  );
endinterface

// File: rtl/dlx_data_mem_responder.sv
// rtl/dlx_data_mem_responder.sv - data-memory responder with posted write buffer and load forwarding
module dlx_data_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4,
  parameter int WR_LAT     = 3
) (
  input logic                     clock,
  input logic                     reset,
  dlx_data_mem_responder_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam int WORDS = 1 << ADDR_W;

  typedef enum logic {IDLE, WRITE} state_t;

  logic [31:0]       mem [WORDS];
  logic [ADDR_W-1:0] buf_idx [WBUF_DEPTH];
  logic [31:0]       buf_data [WBUF_DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic [LAT_W-1:0]  lat;
  logic              store_drop_q, overflow_q;

  logic [ADDR_W-1:0] word_idx;
  logic              addr_ok, push, pop;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PTR_W-1:0]  slot;

  assign word_idx = bus.mem_addr[ADDR_W+1:2];
  assign addr_ok  = (bus.mem_addr[31:ADDR_W+2] == '0);
  // Full is judged on the pre-edge count, so a same-edge pop cannot make room.
  assign push     = bus.mem_en && addr_ok && (count != CNT_W'(WBUF_DEPTH));
  assign pop      = (state == WRITE) && (lat == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= IDLE;
      lat          <= '0;
      store_drop_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      store_drop_q <= bus.mem_en && !push;
      if (bus.mem_en && !push)
        overflow_q <= 1'b1;
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= WRITE;
            lat   <= LAT_W'(WR_LAT - 1);
          end
        end
        WRITE: begin
          if (lat != '0)
            lat <= lat - LAT_W'(1);
          else if ((count != CNT_W'(1)) || push)
            lat <= LAT_W'(WR_LAT - 1);
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_idx[tail]  <= word_idx;
      buf_data[tail] <= bus.memdata_out;
    end
    if (pop)
      mem[buf_idx[head]] <= buf_data[head];
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (buf_idx[slot] == word_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[slot];
      end
    end
  end

  assign bus.memdata_in = !addr_ok ? 32'h0 : (fwd_hit ? fwd_data : mem[word_idx]);
  assign bus.wbuf_count = count;
  assign bus.wbuf_full  = (count == CNT_W'(WBUF_DEPTH));
  assign bus.store_drop = store_drop_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_dlx_data_mem_responder.sv
// tb/tb_dlx_data_mem_responder.sv - self-checking bench for dlx_data_mem_responder
module tb_dlx_data_mem_responder;
  localparam int ADDR_W     = 10;
  localparam int WBUF_DEPTH = 4;
  localparam int WR_LAT     = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dlx_data_mem_responder_if #(.WBUF_DEPTH(WBUF_DEPTH)) bus ();

  dlx_data_mem_responder #(
    .ADDR_W(ADDR_W), .WBUF_DEPTH(WBUF_DEPTH), .WR_LAT(WR_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    longint      done;
  } ent_t;

  ent_t        q[$];
  logic [31:0] marr [int];
  longint      cyc = 0;
  longint      last_pop = -100;
  bit          exp_drop = 0;
  bit          exp_ovf = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each store completes WR_LAT edges after the previous one leaves, or
  // 1+WR_LAT edges after its own push when the engine was idle.
  task automatic model_edge(input logic [31:0] a, input logic en, input logic [31:0] d);
    bit     acc;
    int     pre;
    longint dn;
    cyc++;
    pre = q.size();
    acc = en && (a[31:ADDR_W+2] == '0) && (pre < WBUF_DEPTH);
    while (q.size() > 0 && q[0].done == cyc) begin
      marr[q[0].idx] = q[0].data;
      void'(q.pop_front());
      last_pop = cyc;
    end
    if (acc) begin
      if (q.size() > 0)       dn = q[$].done + WR_LAT;
      else if (last_pop == cyc) dn = cyc + WR_LAT;
      else                    dn = cyc + 1 + WR_LAT;
      q.push_back('{int'(a[ADDR_W+1:2]), d, dn});
    end
    exp_drop = en && !acc;
    if (exp_drop) exp_ovf = 1;
  endtask

  task automatic model_reset();
    q.delete();
    exp_drop = 0;
    exp_ovf  = 0;
    last_pop = -100;
  endtask

  task automatic exp_load(output bit known, output logic [31:0] v);
    logic [31:0] a;
    int          idx;
    bit          found;
    a     = bus.mem_addr;
    idx   = int'(a[ADDR_W+1:2]);
    known = 1;
    v     = '0;
    found = 0;
    if (a[31:ADDR_W+2] == '0) begin
      foreach (q[i]) if (q[i].idx == idx) begin found = 1; v = q[i].data; end
      if (!found) begin
        if (marr.exists(idx)) v = marr[idx];
        else known = 0;
      end
    end
  endtask

  initial forever begin
    bit          known;
    logic [31:0] ev;
    @(posedge clock);
    if (reset) model_edge(bus.mem_addr, bus.mem_en, bus.memdata_out);
    @(negedge clock);
    if (!reset) model_reset();
    chk("wbuf_count", 64'(bus.wbuf_count), 64'(q.size()));
    chk("wbuf_full", 64'(bus.wbuf_full), 64'(q.size() == WBUF_DEPTH));
    chk("store_drop", 64'(bus.store_drop), 64'(exp_drop));
    chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
    exp_load(known, ev);
    if (known) chk("memdata_in", 64'(bus.memdata_in), 64'(ev));
  end

  task automatic apply(input logic [31:0] a, input logic en, input logic [31:0] d);
    bus.mem_addr    = a;
    bus.mem_en      = en;
    bus.memdata_out = d;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    repeat (n) apply(a, 1'b0, 32'h0);
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.mem_addr = a;
    bus.mem_en   = 1'b0;
    #1;
    chk(name, 64'(bus.memdata_in), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.mem_addr    = 32'h0;
    bus.mem_en      = 1'b0;
    bus.memdata_out = 32'h0;
    reset           = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    chk("rst_count", 64'(bus.wbuf_count), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);

    // forwarding of a buffered store, then readback from the array
    apply(32'h10, 1'b1, 32'hDEADBEEF);
    peek("fwd_deadbeef", 32'h10, 32'hDEADBEEF);
    idle(5, 32'h10);
    peek("arr_deadbeef", 32'h10, 32'hDEADBEEF);

    // youngest of two same-address stores wins
    apply(32'h20, 1'b1, 32'h1111);
    apply(32'h20, 1'b1, 32'h2222);
    peek("fwd_young", 32'h20, 32'h2222);
    idle(8, 32'h20);
    peek("arr_young", 32'h20, 32'h2222);
    chk("drained_count", 64'(bus.wbuf_count), 64'd0);

    // reset mid-drain discards pending stores
    apply(32'h30, 1'b1, 32'hA5A5A5A5);
    idle(6, 32'h30);
    apply(32'h30, 1'b1, 32'h1);
    apply(32'h34, 1'b1, 32'h2);
    apply(32'h38, 1'b1, 32'h3);
    idle(1, 32'h30);
    chk("pre_rst_count", 64'(bus.wbuf_count), 64'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 64'(bus.wbuf_count), 64'd0);
    idle(1, 32'h30);
    reset = 1'b1;
    idle(10, 32'h30);
    peek("no_write_after_rst", 32'h30, 32'hA5A5A5A5);

    // five back-to-back stores overflow a four-entry buffer
    for (int i = 0; i < 4; i++) apply(32'h40 + 32'(4 * i), 1'b1, 32'hB000 + 32'(i));
    chk("full_at_4", 64'(bus.wbuf_full), 64'd1);
    apply(32'h50, 1'b1, 32'hB004);
    chk("drop_5th", 64'(bus.store_drop), 64'd1);
    chk("count_after_drop", 64'(bus.wbuf_count), 64'd3);
    idle(1, 32'h40);
    chk("drop_one_pulse", 64'(bus.store_drop), 64'd0);
    chk("overflow_sticky", 64'(bus.overflow), 64'd1);
    idle(12, 32'h44);

    // out-of-range address is rejected and reads as zero
    apply(32'h0001_0000, 1'b1, 32'h12345678);
    chk("bad_addr_drop", 64'(bus.store_drop), 64'd1);
    peek("bad_addr_read", 32'h0001_0000, 32'h0);
    idle(2, 32'h0001_0000);

    // push on a pop edge keeps count; order preserved across wrap
    apply(32'h100, 1'b1, 32'hC0DE0000);
    apply(32'h104, 1'b1, 32'hC0DE0001);
    for (int i = 2; i < 10; i++) begin
      idle(2, 32'h100);
      apply(32'h100 + 32'(4 * i), 1'b1, 32'hC0DE0000 + 32'(i));
      if (i == 2) chk("push_on_pop_count", 64'(bus.wbuf_count), 64'd2);
    end
    idle(40, 32'h100);
    for (int i = 0; i < 10; i++)
      peek("wrap_order", 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
    idle(1, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
